// File: rtl/rng_pkg.sv
// rtl/rng_pkg.sv - shared word type, default sizes and level-width helper for the random byte packer
package rng_pkg;

  localparam int RNG_WORD_W          = 8;
  localparam int RNG_FIFO_DEPTH_LOG2 = 4;

  typedef logic [RNG_WORD_W-1:0] rng_word_t;

  // Level counter needs one extra bit so a full FIFO is distinguishable from an empty one.
  function automatic int rng_level_w(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/rng_sync_fifo.sv
// rtl/rng_sync_fifo.sv - first-word-fall-through synchronous FIFO; a push into a full FIFO is taken when a pop happens on the same edge
module rng_sync_fifo
  import rng_pkg::*;
#(
  parameter int WIDTH      = RNG_WORD_W,
  parameter int DEPTH_LOG2 = RNG_FIFO_DEPTH_LOG2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 push,
  input  logic [WIDTH-1:0]                     push_data,
  input  logic                                 pop,
  output logic [WIDTH-1:0]                     pop_data,
  output logic                                 full,
  output logic                                 empty,
  output logic [rng_level_w(DEPTH_LOG2)-1:0]   level
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int LEVEL_W = rng_level_w(DEPTH_LOG2);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (level == LEVEL_W'(DEPTH));
  assign empty    = (level == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/random_byte_packer.sv
// rtl/random_byte_packer.sv - packs strobed random bits LSB-first into words and queues them for the transmitter
// Optional drop_count output is enabled by defining RNG_PACKER_DROP_COUNT_EN.
module random_byte_packer
  import rng_pkg::*;
#(
  parameter int WORD_W          = RNG_WORD_W,
  parameter int FIFO_DEPTH_LOG2 = RNG_FIFO_DEPTH_LOG2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      random_bit,
  input  logic                                      random_bit_ready,
  output logic [WORD_W-1:0]                         data_out,
  output logic                                      data_valid,
  input  logic                                      data_ready,
  output logic [rng_level_w(FIFO_DEPTH_LOG2)-1:0]   fifo_level,
  output logic                                      overflow,
  input  logic                                      overflow_clear
`ifdef RNG_PACKER_DROP_COUNT_EN
  ,
  output logic [15:0]                               drop_count
`endif
);

  localparam int              CNT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] word_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic              word_done;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              drop;

  // The completed word includes the bit arriving on this edge, so merge it combinationally.
  always_comb begin
    word_next          = shift_reg;
    word_next[bit_cnt] = random_bit;
  end

  assign word_done  = random_bit_ready && (bit_cnt == LAST_BIT);
  assign data_valid = !fifo_empty;
  assign pop        = data_valid && data_ready;
  assign drop       = word_done && fifo_full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (random_bit_ready) begin
      shift_reg <= word_next;
      bit_cnt   <= word_done ? '0 : bit_cnt + 1'b1;
    end
  end

  // A drop on the same edge as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clear) begin
      overflow <= 1'b0;
    end
  end

`ifdef RNG_PACKER_DROP_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop) begin
      if (overflow_clear) begin
        drop_count <= 16'd1;
      end else if (drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end else if (overflow_clear) begin
      drop_count <= '0;
    end
  end
`endif

  rng_sync_fifo #(
    .WIDTH      (WORD_W),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (word_done),
    .push_data (word_next),
    .pop       (pop),
    .pop_data  (data_out),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_random_byte_packer.sv
// tb/tb_random_byte_packer.sv - randomized and directed checks of random_byte_packer against a queue-based reference model
module tb_random_byte_packer;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       random_bit = 1'b0;
  logic       random_bit_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready = 1'b0;
  logic [4:0] fifo_level;
  logic       overflow;
  logic       overflow_clear = 1'b0;
`ifdef RNG_PACKER_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] q[$];
  int         nbits;
  logic [7:0] acc;
  logic       m_ovf;
  int         m_dc;

  random_byte_packer dut (
    .clk              (clk),
    .rst              (rst),
    .random_bit       (random_bit),
    .random_bit_ready (random_bit_ready),
    .data_out         (data_out),
    .data_valid       (data_valid),
    .data_ready       (data_ready),
    .fifo_level       (fifo_level),
    .overflow         (overflow),
    .overflow_clear   (overflow_clear)
`ifdef RNG_PACKER_DROP_COUNT_EN
    ,
    .drop_count       (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    nbits = 0;
    acc   = 8'h00;
    m_ovf = 1'b0;
    m_dc  = 0;
  endtask

  task automatic model_edge(input logic s, input logic b, input logic r, input logic c);
    bit pop_ok;
    bit done;
    bit dropped;
    pop_ok  = (q.size() > 0) && r;
    done    = 1'b0;
    dropped = 1'b0;
    if (s) begin
      acc = acc | (8'(b) << nbits);
      nbits++;
      done = (nbits == 8);
    end
    if (done && q.size() >= DEPTH && !pop_ok) dropped = 1'b1;
    if (pop_ok) void'(q.pop_front());
    if (done) begin
      if (!dropped) q.push_back(acc);
      acc   = 8'h00;
      nbits = 0;
    end
    if (dropped) begin
      m_ovf = 1'b1;
      m_dc  = c ? 1 : ((m_dc < 65535) ? m_dc + 1 : 65535);
    end else if (c) begin
      m_ovf = 1'b0;
      m_dc  = 0;
    end
  endtask

  task automatic compare_state();
    check("valid", data_valid, q.size() != 0);
    check("level", fifo_level, q.size());
    if (q.size() != 0) check("data", data_out, q[0]);
    check("overflow", overflow, m_ovf);
`ifdef RNG_PACKER_DROP_COUNT_EN
    check("drop_count", drop_count, m_dc);
`endif
  endtask

  task automatic step(input logic s, input logic b, input logic r, input logic c);
    random_bit_ready = s;
    random_bit       = b;
    data_ready       = r;
    overflow_clear   = c;
    @(posedge clk);
    model_edge(s, b, r, c);
    #1;
    compare_state();
  endtask

  task automatic do_reset();
    random_bit_ready = 1'b0;
    data_ready       = 1'b0;
    overflow_clear   = 1'b0;
    rst              = 1'b1;
    #2;
    model_reset();
    check("rst_data_out", data_out, 0);
    compare_state();
    #1;
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] value, input logic r);
    for (int i = 0; i < 8; i++) step(1'b1, value[i], r, 1'b0);
  endtask

  initial begin
    logic [7:0] v;
    model_reset();
    #3;
    do_reset();

    // Bits 1,0,1,1,0,0,1,0 LSB-first form 8'h4D.
    v = 8'h4D;
    send_byte(v, 1'b1);
    check("t1_valid", data_valid, 1);
    check("t1_data", data_out, 8'h4D);
    check("t1_level", fifo_level, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t1_level_after", fifo_level, 0);

    // Sixteen back-to-back ones with ready low, then drain.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t2_level", fifo_level, 2);
    check("t2_data", data_out, 8'hFF);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t2_data2", data_out, 8'hFF);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t2_empty", data_valid, 0);

    // Seventeen words into a stalled FIFO: one drop, first sixteen intact.
    do_reset();
    for (int w = 0; w < 17; w++) send_byte(8'($urandom), 1'b0);
    check("t3_level", fifo_level, 16);
    check("t3_overflow", overflow, 1);
`ifdef RNG_PACKER_DROP_COUNT_EN
    check("t3_drop_count", drop_count, 1);
`endif
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t3_drained", data_valid, 0);

    // Full FIFO, word completes while the head is popped: accepted, no drop.
    do_reset();
    for (int w = 0; w < 16; w++) send_byte(8'($urandom), 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    check("t4_level", fifo_level, 16);
    check("t4_overflow", overflow, 0);

    // Clear coinciding with a drop keeps overflow; an isolated clear releases it.
    for (int i = 0; i < 7; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("t6_overflow_set_wins", overflow, 1);
`ifdef RNG_PACKER_DROP_COUNT_EN
    check("t6_drop_count_one", drop_count, 1);
`endif
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_overflow_cleared", overflow, 0);
`ifdef RNG_PACKER_DROP_COUNT_EN
    check("t6_drop_count_zero", drop_count, 0);
`endif

    // Reset mid-word discards partial bits.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    do_reset();
    v = 8'hA5;
    send_byte(v, 1'b0);
    check("t5_data", data_out, 8'hA5);
    check("t5_level", fifo_level, 1);

    // Random traffic with varying downstream back-pressure.
    for (int phase = 0; phase < 3; phase++) begin
      for (int i = 0; i < 800; i++) begin
        logic s, r, c;
        s = ($urandom_range(0, 3) != 0);
        r = (phase == 0) ? ($urandom_range(0, 1) == 0)
          : (phase == 1) ? ($urandom_range(0, 15) == 0)
          :                ($urandom_range(0, 7) != 0);
        c = ($urandom_range(0, 63) == 0);
        step(s, 1'($urandom), r, c);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
